// File: rtl/t02_telemetry_pkg.sv
// Shared types and constants for the UART telemetry framer: FSM states,
// frame header bytes, byte positions within the 12-byte frame and the
// payload snapshot layout.
package t02_telemetry_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND,
        HOLD
    } state_t;

    localparam logic [7:0] HDR0      = 8'hA5;
    localparam logic [7:0] HDR1      = 8'h5A;
    localparam int         FRAME_LEN = 12;

    localparam logic [3:0] IDX_HDR0     = 4'd0;
    localparam logic [3:0] IDX_HDR1     = 4'd1;
    localparam logic [3:0] IDX_SEQ      = 4'd2;
    localparam logic [3:0] IDX_ROLL_HI  = 4'd3;
    localparam logic [3:0] IDX_ROLL_LO  = 4'd4;
    localparam logic [3:0] IDX_PITCH_HI = 4'd5;
    localparam logic [3:0] IDX_PITCH_LO = 4'd6;
    localparam logic [3:0] IDX_POS      = 4'd7;
    localparam logic [3:0] IDX_DET      = 4'd8;
    localparam logic [3:0] IDX_DUTY_X   = 4'd9;
    localparam logic [3:0] IDX_DUTY_Y   = 4'd10;
    localparam logic [3:0] IDX_CSUM     = 4'd11;

    // Everything that goes on the wire besides the headers and checksum.
    typedef struct packed {
        logic [7:0]  seq;
        logic [15:0] roll;
        logic [15:0] pitch;
        logic [3:0]  pos_x;
        logic [3:0]  pos_y;
        logic        det;
        logic [7:0]  duty_x;
        logic [7:0]  duty_y;
    } payload_t;

    // XOR of every payload byte (frame bytes 2..10).
    function automatic logic [7:0] frame_checksum(input payload_t p);
        return p.seq ^ p.roll[15:8] ^ p.roll[7:0] ^ p.pitch[15:8] ^ p.pitch[7:0]
             ^ {p.pos_x, p.pos_y} ^ {7'b0, p.det} ^ p.duty_x ^ p.duty_y;
    endfunction

endpackage

// File: rtl/t02_telemetry_frame.sv
// Payload snapshot and frame byte selector. The snapshot is taken once per
// frame so every byte of a frame describes the same instant.
module t02_telemetry_frame
    import t02_telemetry_pkg::*;
(
    input  logic        hz100,
    input  logic        reset,
    input  logic        snap,
    input  logic [7:0]  seq,
    input  logic [15:0] tilt_roll,
    input  logic [15:0] tilt_pitch,
    input  logic        ball_detected,
    input  logic [3:0]  ball_pos_x,
    input  logic [3:0]  ball_pos_y,
    input  logic [7:0]  duty_x,
    input  logic [7:0]  duty_y,
    input  logic [3:0]  byte_idx,
    output logic [7:0]  frame_byte
);

    payload_t snap_q;

    // Capture the live payload on the single SNAP cycle, hold it otherwise.
    always_ff @(posedge hz100) begin
        // NOTE: non-blocking assignments in clocked blocks so every register
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            snap_q <= '0;
        end else if (snap) begin
            snap_q <= '{seq: seq, roll: tilt_roll, pitch: tilt_pitch,
                        pos_x: ball_pos_x, pos_y: ball_pos_y, det: ball_detected,
                        duty_x: duty_x, duty_y: duty_y};
        end
    end

    // Select the frame byte addressed by byte_idx.
    always_comb begin
        // NOTE: default assignment first so no path leaves frame_byte unassigned
        // (which would infer a latch).
        frame_byte = 8'h00;
        case (byte_idx)
            IDX_HDR0:     frame_byte = HDR0;
            IDX_HDR1:     frame_byte = HDR1;
            IDX_SEQ:      frame_byte = snap_q.seq;
            IDX_ROLL_HI:  frame_byte = snap_q.roll[15:8];
            IDX_ROLL_LO:  frame_byte = snap_q.roll[7:0];
            IDX_PITCH_HI: frame_byte = snap_q.pitch[15:8];
            IDX_PITCH_LO: frame_byte = snap_q.pitch[7:0];
            IDX_POS:      frame_byte = {snap_q.pos_x, snap_q.pos_y};
            IDX_DET:      frame_byte = {7'b0, snap_q.det};
            IDX_DUTY_X:   frame_byte = snap_q.duty_x;
            IDX_DUTY_Y:   frame_byte = snap_q.duty_y;
            IDX_CSUM:     frame_byte = frame_checksum(snap_q);
            default:      frame_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/t02_uart_telemetry.sv
// Telemetry framer: every PERIOD_TICKS clk_en ticks it snapshots the
// balancer state and streams a 12-byte frame over the UART byte interface.
// Purely observational; triggers that arrive mid-frame are counted as dropped.
module t02_uart_telemetry
    import t02_telemetry_pkg::*;
#(
    parameter int PERIOD_TICKS = 50,
    parameter int ACK_TIMEOUT  = 4096
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        en,
    input  logic [15:0] tilt_roll,
    input  logic [15:0] tilt_pitch,
    input  logic        ball_detected,
    input  logic [3:0]  ball_pos_x,
    input  logic [3:0]  ball_pos_y,
    input  logic [7:0]  duty_x,
    input  logic [7:0]  duty_y,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic        frame_err,
    output logic [7:0]  dropped
);

    localparam int TW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(PERIOD_TICKS - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic          trigger;
    logic [3:0]    byte_idx;
    logic [7:0]    seq;
    logic [AW-1:0] to_cnt;
    logic [7:0]    frame_byte;

    // Trigger is combinational so the FSM reacts on the wrapping edge itself.
    assign trigger = clk_en && (tick_cnt == TICK_LAST);

    // Free-running frame period divider; runs regardless of en.
    always_ff @(posedge hz100) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (clk_en) begin
            tick_cnt <= trigger ? '0 : tick_cnt + 1'b1;
        end
    end

    t02_telemetry_frame u_frame (
        .hz100         (hz100),
        .reset         (reset),
        .snap          (state == SNAP),
        .seq           (seq),
        .tilt_roll     (tilt_roll),
        .tilt_pitch    (tilt_pitch),
        .ball_detected (ball_detected),
        .ball_pos_x    (ball_pos_x),
        .ball_pos_y    (ball_pos_y),
        .duty_x        (duty_x),
        .duty_y        (duty_y),
        .byte_idx      (byte_idx),
        .frame_byte    (frame_byte)
    );

    // Frame FSM with registered handshake outputs and the drop counter.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state     <= IDLE;
            txdata    <= 8'h00;
            txclk     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            dropped   <= 8'h00;
            byte_idx  <= 4'd0;
            seq       <= 8'h00;
            to_cnt    <= '0;
        end else begin
            txclk     <= 1'b0;
            frame_err <= 1'b0;

            // Any trigger outside IDLE is lost, including one on the last HOLD cycle.
            if (trigger && state != IDLE && dropped != 8'hFF) begin
                dropped <= dropped + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (trigger && en) begin
                        busy  <= 1'b1;
                        state <= SNAP;
                    end
                end
                SNAP: begin
                    byte_idx <= 4'd0;
                    state    <= SEND;
                end
                SEND: begin
                    if (txready) begin
                        txdata <= frame_byte;
                        txclk  <= 1'b1;
                        to_cnt <= '0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (!txready) begin
                        if (byte_idx == IDX_CSUM) begin
                            busy  <= 1'b0;
                            seq   <= seq + 8'd1;
                            state <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= SEND;
                        end
                    end else if (to_cnt == ACK_LAST) begin
                        // UART never took the byte: abort, but still burn a
                        // sequence number so the host sees the gap.
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        seq       <= seq + 8'd1;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t02_uart_telemetry.sv
// Directed bench for the UART telemetry framer: a simple UART model that
// accepts each strobed byte, a clk_en generator with adjustable spacing and
// a byte monitor whose captures are compared against hand-computed frames.
module tb_t02_uart_telemetry;

    localparam int P   = 50;
    localparam int ACK = 16;

    logic        hz100 = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        en;
    logic [15:0] tilt_roll;
    logic [15:0] tilt_pitch;
    logic        ball_detected;
    logic [3:0]  ball_pos_x;
    logic [3:0]  ball_pos_y;
    logic [7:0]  duty_x;
    logic [7:0]  duty_y;
    logic        txready;
    logic [7:0]  txdata;
    logic        txclk;
    logic        busy;
    logic        frame_err;
    logic [7:0]  dropped;

    int n_checks = 0;
    int n_fail   = 0;

    t02_uart_telemetry #(.PERIOD_TICKS(P), .ACK_TIMEOUT(ACK)) dut (
        .hz100         (hz100),
        .reset         (reset),
        .clk_en        (clk_en),
        .en            (en),
        .tilt_roll     (tilt_roll),
        .tilt_pitch    (tilt_pitch),
        .ball_detected (ball_detected),
        .ball_pos_x    (ball_pos_x),
        .ball_pos_y    (ball_pos_y),
        .duty_x        (duty_x),
        .duty_y        (duty_y),
        .txready       (txready),
        .txdata        (txdata),
        .txclk         (txclk),
        .busy          (busy),
        .frame_err     (frame_err),
        .dropped       (dropped)
    );

    always #5 hz100 = ~hz100;

    // Cycle counter and a model of the tick divider (position within the period).
    int cyc = 0;
    int m_tick = 0;
    int trig_cyc = 0;
    always @(posedge hz100) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_tick <= 0;
        end else if (clk_en) begin
            m_tick <= (m_tick == P - 1) ? 0 : m_tick + 1;
            if (m_tick == P - 1) trig_cyc <= cyc + 1;
        end
    end

    // Byte monitor: capture every strobed byte and its cycle, and abort pulses.
    logic [7:0] rx_q[$];
    int         st_q[$];
    int         err_cyc = 0;
    always @(negedge hz100) begin
        if (txclk) begin
            rx_q.push_back(txdata);
            st_q.push_back(cyc);
        end
        if (frame_err) err_cyc = cyc;
    end

    // clk_en generator: one pulse every tick_gap cycles, none when tick_gap is 0.
    int tick_gap = 0;
    initial begin
        int gap_cnt;
        gap_cnt = 0;
        clk_en  = 1'b0;
        forever begin
            @(negedge hz100);
            if (tick_gap != 0 && gap_cnt >= tick_gap - 1) begin
                clk_en  = 1'b1;
                gap_cnt = 0;
            end else begin
                clk_en  = 1'b0;
                gap_cnt++;
            end
        end
    end

    // UART model: txready drops 3 cycles after a strobe and stays low for
    // low_cycles; when stuck is set it ignores strobes entirely.
    bit stuck      = 1'b0;
    int low_cycles = 20;
    initial begin
        int n;
        txready = 1'b1;
        forever begin
            @(negedge hz100);
            if (txclk && !stuck) begin
                repeat (3) @(negedge hz100);
                txready = 1'b0;
                n = 0;
                while (n < low_cycles) begin
                    @(negedge hz100);
                    n++;
                end
                txready = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input logic v, input int maxc, input string tag);
        int n = 0;
        while (busy !== v && n < maxc) begin
            @(negedge hz100);
            n++;
        end
        check(tag, 32'(busy), 32'(v));
    endtask

    task automatic wait_bytes(input int cnt, input int maxc, input string tag);
        int n = 0;
        while (rx_q.size() < cnt && n < maxc) begin
            @(negedge hz100);
            n++;
        end
        check(tag, 32'(rx_q.size() >= cnt), 32'd1);
    endtask

    task automatic wait_tick(input int v, input int maxc, input string tag);
        int n = 0;
        while (m_tick != v && n < maxc) begin
            @(negedge hz100);
            n++;
        end
        check(tag, 32'(m_tick), 32'(v));
    endtask

    task automatic wait_dropped(input logic [7:0] v, input int maxc, input string tag);
        int n = 0;
        while (dropped !== v && n < maxc) begin
            @(negedge hz100);
            n++;
        end
        check(tag, 32'(dropped), 32'(v));
    endtask

    // Expected frame from field values; checksum is XOR of bytes 2..10.
    task automatic build_frame(input logic [7:0] s, input logic [15:0] r, input logic [15:0] p,
                               input logic [3:0] px, input logic [3:0] py, input logic det,
                               input logic [7:0] dx, input logic [7:0] dy,
                               output logic [7:0] e[12]);
        e[0]  = 8'hA5;
        e[1]  = 8'h5A;
        e[2]  = s;
        e[3]  = r[15:8];
        e[4]  = r[7:0];
        e[5]  = p[15:8];
        e[6]  = p[7:0];
        e[7]  = {px, py};
        e[8]  = {7'b0, det};
        e[9]  = dx;
        e[10] = dy;
        e[11] = 8'h00;
        for (int i = 2; i <= 10; i++) e[11] = e[11] ^ e[i];
    endtask

    task automatic check_frame(input string nm, input logic [7:0] e[12]);
        check({nm, "_len"}, 32'(rx_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_b%0d", nm, i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(e[i]));
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        st_q.delete();
    endtask

    // Frame 0 worked by hand: payload XOR 00^FF^9C^00^32^35^01^82^7D = 9A.
    logic [7:0] f1_exp[12] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h9C, 8'h00,
                               8'h32, 8'h35, 8'h01, 8'h82, 8'h7D, 8'h9A};

    initial begin
        logic [7:0] e[12];

        reset         = 1'b1;
        en            = 1'b0;
        tilt_roll     = 16'hFF9C;
        tilt_pitch    = 16'h0032;
        ball_pos_x    = 4'd3;
        ball_pos_y    = 4'd5;
        ball_detected = 1'b1;
        duty_x        = 8'd130;
        duty_y        = 8'd125;

        // Reset state
        repeat (3) @(negedge hz100);
        check("rst_txdata", 32'(txdata), 32'h00);
        check("rst_txclk", 32'(txclk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_dropped", 32'(dropped), 32'd0);
        reset = 1'b0;

        // Frame seq 0; roll changes after byte 3 but the frame stays frozen
        en       = 1'b1;
        tick_gap = 10;
        wait_busy(1'b1, 1200, "f1_start");
        wait_bytes(4, 400, "f1_b3_seen");
        tilt_roll = 16'h1234;
        wait_busy(1'b0, 800, "f1_done");
        check_frame("f1", f1_exp);
        check("f1_latency", (st_q.size() > 0) ? 32'(st_q[0] - trig_cyc) : 32'hFFFF, 32'd2);
        check("f1_dropped", 32'(dropped), 32'd0);

        // Frame seq 1 carries the new roll; en drops mid-frame, frame completes
        clear_rx();
        wait_busy(1'b1, 700, "f2_start");
        wait_bytes(6, 400, "f2_b5_seen");
        en = 1'b0;
        wait_busy(1'b0, 800, "f2_done");
        en = 1'b1;
        build_frame(8'd1, 16'h1234, 16'h0032, 4'd3, 4'd5, 1'b1, 8'd130, 8'd125, e);
        check_frame("f2", e);

        // ACK timeout: UART never drops txready
        stuck = 1'b1;
        clear_rx();
        wait_busy(1'b1, 700, "to_start");
        wait_busy(1'b0, 100, "to_abort");
        check("to_err_pulse", 32'(frame_err), 32'd1);
        @(negedge hz100);
        check("to_err_width", 32'(frame_err), 32'd0);
        check("to_strobes", 32'(rx_q.size()), 32'd1);
        check("to_byte0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'hA5);
        check("to_latency", (st_q.size() > 0) ? 32'(err_cyc - st_q[0]) : 32'hFFFF, 32'(ACK));
        stuck = 1'b0;

        // Aborted frame consumed seq 2, so the next one is seq 3
        clear_rx();
        wait_busy(1'b1, 700, "f4_start");
        wait_busy(1'b0, 800, "f4_done");
        build_frame(8'd3, 16'h1234, 16'h0032, 4'd3, 4'd5, 1'b1, 8'd130, 8'd125, e);
        check_frame("f4", e);

        // Slow UART with a trigger every 50 cycles: dropped saturates at 255
        clear_rx();
        low_cycles = 3000;
        tick_gap   = 1;
        wait_dropped(8'hFF, 20000, "drop_reach");
        repeat (200) @(negedge hz100);
        check("drop_sat", 32'(dropped), 32'hFF);
        check("drop_busy", 32'(busy), 32'd1);
        tick_gap   = 0;
        low_cycles = 20;
        wait_busy(1'b0, 3000, "f5_done");
        build_frame(8'd4, 16'h1234, 16'h0032, 4'd3, 4'd5, 1'b1, 8'd130, 8'd125, e);
        check_frame("f5", e);

        // en low: triggers ignored and not counted as dropped
        en = 1'b0;
        clear_rx();
        tick_gap = 2;
        repeat (400) @(negedge hz100);
        check("en_off_strobes", 32'(rx_q.size()), 32'd0);
        check("en_off_busy", 32'(busy), 32'd0);
        check("en_off_dropped", 32'(dropped), 32'hFF);
        // en raised mid-period: nothing starts until the next wrap
        wait_tick(25, 200, "en_mid_tick");
        en = 1'b1;
        wait_tick(P - 1, 200, "en_last_tick");
        check("en_early_strobes", 32'(rx_q.size()), 32'd0);
        check("en_early_busy", 32'(busy), 32'd0);
        wait_busy(1'b1, 10, "en_wrap_start");
        check("en_wrap_tick", 32'(m_tick), 32'd0);
        tick_gap = 0;
        wait_busy(1'b0, 1000, "f6_done");
        build_frame(8'd5, 16'h1234, 16'h0032, 4'd3, 4'd5, 1'b1, 8'd130, 8'd125, e);
        check_frame("f6", e);

        // Reset during byte 5 abandons the frame; next frame restarts at seq 0
        clear_rx();
        tick_gap = 10;
        wait_bytes(6, 1200, "rst_b5_seen");
        reset = 1'b1;
        @(negedge hz100);
        check("mid_rst_txclk", 32'(txclk), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_dropped", 32'(dropped), 32'd0);
        check("mid_rst_txdata", 32'(txdata), 32'h00);
        clear_rx();
        reset = 1'b0;
        wait_busy(1'b1, 1200, "f7_start");
        wait_busy(1'b0, 1000, "f7_done");
        build_frame(8'd0, 16'h1234, 16'h0032, 4'd3, 4'd5, 1'b1, 8'd130, 8'd125, e);
        check_frame("f7", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

endmodule
